// File: rtl/core_pkt_encoder.sv
// core_pkt_encoder
//   Source-side packet encoder. Each 8-bit core word {data[3:0], ip[3:0]} is
//   Hamming(7,4)-encoded into an 11-bit router flit {codeword[6:0], ip[3:0]}.
//   The flit is stored in a small circular FIFO and presented to the router
//   injection port.
//
//   Codeword layout, bit6..bit0 = {D4, D3, D2, P4, D1, P2, P1}.
//
// Parameters
//   DEPTH      FIFO entries, power of two, 2..16.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   core word available
//   in_data    {data[3:0], ip[3:0]}
//   in_ready   FIFO not full
//   out_valid  flit available (FIFO not empty)
//   out_data   {codeword[6:0], ip[3:0]} of the head entry (registered)
//   out_ready  router consumes the head flit
//   occupancy  number of stored flits
//   inj_arm    (HAMMING_ERR_INJECT_EN only) arm a single-bit codeword error
//   inj_pos    (HAMMING_ERR_INJECT_EN only) codeword bit to flip, 7 = no flip
//
// Optional feature macro: HAMMING_ERR_INJECT_EN
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on the stored count (never on out_ready),
// so a full FIFO refuses a word even when a pop happens on the same edge.
// The producer may hold in_valid with stable data while in_ready is low.
// out_valid/out_data stay stable until the flit is consumed.

module core_pkt_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [10:0]              out_data,
  input  logic                     out_ready,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic                     inj_arm,
  input  logic [2:0]               inj_pos,
`endif
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Hamming(7,4) encoder: data bits placed at positions 3,5,6,7 (1-based),
  // parities chosen so the receiver's syndrome is zero on a clean flit.
  function automatic logic [10:0] encode_flit(input logic [7:0] word);
    logic [3:0] d;
    logic [6:0] cw;
    d     = word[7:4];
    cw[2] = d[0];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    cw[0] = cw[2] ^ cw[4] ^ cw[6];
    cw[1] = cw[2] ^ cw[5] ^ cw[6];
    cw[3] = cw[4] ^ cw[5] ^ cw[6];
    return {cw, word[3:0]};
  endfunction

  logic [10:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [10:0]       head_q;

  logic              push;
  logic              pop;
  logic [10:0]       enc_flit;
  logic [PTR_W-1:0]  rd_next;
  logic [CNT_W-1:0]  remain;
  logic              head_load;
  logic [10:0]       head_next;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign occupancy = count;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign enc_flit = encode_flit(in_data);

  // Next head selection. "remain" is what is left of the old contents after
  // this edge's pop. If something remains, the head is the stored entry at
  // the advanced read pointer; if nothing remains but a word is pushed, the
  // new flit becomes the head directly (1-cycle latency). Otherwise the last
  // head value is held.
  always_comb begin
    rd_next   = pop ? rd_ptr + 1'b1 : rd_ptr;
    remain    = count - {{PTR_W{1'b0}}, pop};
    head_load = 1'b0;
    head_next = head_q;
    if (remain != '0) begin
      head_load = 1'b1;
      head_next = mem[rd_next];
    end else if (push) begin
      head_load = 1'b1;
      head_next = enc_flit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_flit;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (head_load) begin
        head_q <= head_next;
      end
    end
  end

`ifdef HAMMING_ERR_INJECT_EN
  logic       inj_armed;
  logic [2:0] inj_pos_q;
  logic [6:0] flip_mask;

  // A new arm always wins over the clearing pop on the same edge, so the
  // flip lands on the flit popped after the arm, not the one leaving now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_armed <= 1'b0;
      inj_pos_q <= '0;
    end else if (inj_arm) begin
      inj_armed <= 1'b1;
      inj_pos_q <= inj_pos;
    end else if (pop) begin
      inj_armed <= 1'b0;
    end
  end

  // Position 7 shifts the single bit out of the 7-bit mask: no flip.
  assign flip_mask = inj_armed ? 7'(8'b1 << inj_pos_q) : 7'b0;
  assign out_data  = head_q ^ {flip_mask, 4'b0000};
`else
  assign out_data = head_q;
`endif

endmodule

// File: tb/tb_core_pkt_encoder.sv
module tb_core_pkt_encoder;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [10:0] out_data;
  logic        out_ready;
  logic [2:0]  occupancy;
`ifdef HAMMING_ERR_INJECT_EN
  logic        inj_arm;
  logic [2:0]  inj_pos;
`endif

  always #5 clk = ~clk;

  core_pkt_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_arm   (inj_arm),
    .inj_pos   (inj_pos),
`endif
    .occupancy (occupancy)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference encoder written from the parity equations.
  function automatic logic [10:0] ref_enc(input logic [7:0] w);
    logic d1, d2, d3, d4;
    d1 = w[4]; d2 = w[5]; d3 = w[6]; d4 = w[7];
    return {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4, w[3:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive inputs, advance one edge, settle #1 away from the edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Streaming step that keeps the expected queue in sync with handshakes.
  task automatic sb_step(input logic iv, input logic [7:0] d, input logic ordy, input string tag);
    logic do_pop;
    logic do_push;
    do_pop  = out_valid && ordy;
    do_push = iv && in_ready;
    step(iv, d, ordy);
    if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(ref_enc(d));
    check({tag, "_occ"}, 32'(occupancy), 32'(exp_q.size()));
    if (exp_q.size() > 0) check({tag, "_data"}, 32'(out_data), 32'(exp_q[0]));
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  din;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [2:0]  e_occ;
    logic [10:0] e_data;
  } vec_t;

  localparam int NV = 16;
  vec_t vt[NV];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
    inj_arm   = 1'b0;
    inj_pos   = 3'd0;
`endif

    //          iv  din    ordy ov ir occ   data
    vt[0]  = '{1'b1, 8'hB3, 1'b0, 1'b1, 1'b1, 3'd1, 11'h553};
    vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 11'h000};
    vt[2]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 3'd1, 11'h005};
    vt[3]  = '{1'b1, 8'hFA, 1'b1, 1'b1, 1'b1, 3'd1, 11'h7FA};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 11'h000};
    vt[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 3'd1, 11'h071};
    vt[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 3'd2, 11'h071};
    vt[7]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 3'd3, 11'h071};
    vt[8]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 3'd4, 11'h071};
    vt[9]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 3'd4, 11'h071};
    vt[10] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 3'd3, 11'h192};
    vt[11] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 3'd4, 11'h192};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 11'h1E3};
    vt[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 11'h2A4};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 11'h2D5};
    vt[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 11'h000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ",  32'(occupancy), 32'd0);
    check("rst_ov",   32'(out_valid),  32'd0);
    check("rst_ir",   32'(in_ready),   32'd1);
    check("rst_data", 32'(out_data),   32'h000);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      step(vt[i].iv, vt[i].din, vt[i].ordy);
      check($sformatf("vec%0d_ov", i),  32'(out_valid), 32'(vt[i].e_ov));
      check($sformatf("vec%0d_ir", i),  32'(in_ready),  32'(vt[i].e_ir));
      check($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vt[i].e_occ));
      if (vt[i].e_ov) check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].e_data));
    end

    // Reset mid-operation flushes stored flits
    step(1'b1, 8'hC7, 1'b0);
    step(1'b1, 8'h9E, 1'b0);
    step(1'b1, 8'h61, 1'b0);
    check("pre_rst_occ", 32'(occupancy), 32'd3);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov",  32'(out_valid), 32'd0);
    check("mid_rst_occ", 32'(occupancy), 32'd0);
    check("mid_rst_ir",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check($sformatf("post_rst%0d_ov", i), 32'(out_valid), 32'd0);
      check($sformatf("post_rst%0d_occ", i), 32'(occupancy), 32'd0);
    end

    // Full-rate streaming with an irregular stall, scoreboard-checked
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      sb_step(1'b1, 8'(i * 37 + 5), (i % 5) != 3, $sformatf("strm%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      sb_step(1'b0, 8'h00, 1'b1, $sformatf("drain%0d", i));
    end
    check("drain_ov", 32'(out_valid), 32'd0);

`ifdef HAMMING_ERR_INJECT_EN
    // Arm a flip of codeword bit 2, then push 0xB3
    inj_arm = 1'b1;
    inj_pos = 3'd2;
    step(1'b0, 8'h00, 1'b0);
    inj_arm = 1'b0;
    step(1'b1, 8'hB3, 1'b0);
    check("inj_data", 32'(out_data), 32'h513);
    begin
      logic [6:0] cw;
      logic [2:0] syn;
      cw = out_data[10:4];
      syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
      syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
      syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
      if (syn != 3'd0) cw[syn - 3'd1] = ~cw[syn - 3'd1];
      check("inj_corrected", 32'({cw[6], cw[5], cw[4], cw[2], out_data[3:0]}), 32'hB3);
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hB3, 1'b0);
    check("inj_clean", 32'(out_data), 32'h553);
    step(1'b0, 8'h00, 1'b1);
`endif

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_pkt_encoder.md
# core_pkt_encoder

Source-side packet encoder for the core network interface. It accepts 8-bit core words (4-bit data nibble plus 4-bit destination IP) and Hamming(7,4)-encodes the nibble into the 11-bit router flit format. The flit format is 7-bit codeword followed by 4-bit IP. Flits are buffered in a small FIFO and handed to the router injection port. This is the exact inverse of the sink-side Hamming correction stage, so a flit produced here and corrected there returns the original 8-bit word.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  core word available.
- in_data  in  8  {data[3:0], ip[3:0]}; data nibble in bits [7:4], IP in bits [3:0].
- in_ready  out  1  word accepted on any edge where in_valid && in_ready.
- out_valid  out  1  flit available.
- out_data  out  11  {codeword[6:0], ip[3:0]}.
- out_ready  in  1  flit consumed on any edge where out_valid && out_ready.
- occupancy  out  $clog2(DEPTH)+1  entries currently stored.
- inj_arm  in  1  present only with HAMMING_ERR_INJECT_EN; arm a single-bit error.
- inj_pos  in  3  present only with HAMMING_ERR_INJECT_EN; codeword bit to flip (0..6).

## Operation
- Codeword layout, bit6..bit0: {D4, D3, D2, P4, D1, P2, P1}.
- Data mapping: D1=data[0]→cw[2], D2=data[1]→cw[4], D3=data[2]→cw[5], D4=data[3]→cw[6].
- Parity bits:
  - P1 = cw[2]^cw[4]^cw[6]
  - P2 = cw[2]^cw[5]^cw[6]
  - P4 = cw[4]^cw[5]^cw[6]
- The parity definitions make the receiver's syndrome exactly 0 on a clean flit.
- Encoding is combinational on in_data. The encoded 11-bit flit is written to the FIFO on the accept edge; the IP passes through unchanged.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Count register of $clog2(DEPTH)+1 bits, driven out as occupancy.
  - Registered out_data comes from the head entry.
- in_ready = (count != DEPTH), with no combinational dependence on out_ready.
- When full, a new word is not accepted even if a pop happens in the same cycle.
- out_valid = (count != 0).
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
- Push when empty: the flit appears on out_data/out_valid in the next cycle.
- Pop when count==1 with no push: out_valid drops in the next cycle.
- out_data while out_valid=0 holds the last head value. The bench must not check it.
- FIFO order is strict; there is no reordering or dropping.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - Pointers and count go to 0, so occupancy=0, out_valid=0, in_ready=1.
  - Storage and out_data go to 0.
  - Any armed injection is cleared.
- Reset mid-operation flushes all stored flits; none are emitted after release.
- Latency is 1 cycle from the accept edge to out_valid.
- Throughput is 1 flit per cycle when out_ready is held high.
- A producer may hold in_valid with stable in_data while in_ready=0.
- out_valid/out_data stay stable until consumed.

## Configuration
- HAMMING_ERR_INJECT_EN defined:
  - inj_arm/inj_pos ports exist, along with a 1-bit armed flag and a 3-bit position register.
  - On an inj_arm=1 edge, the flag is set and inj_pos is latched; a later arm overwrites an earlier one.
  - The next flit popped has codeword bit pos inverted on out_data; the flag clears on that pop.
  - pos=7 is a no-op that still clears the flag.
  - Arm and pop on the same edge: the flip applies to the next flit popped, not the current one.
- HAMMING_ERR_INJECT_EN undefined: the ports and registers are absent, and out_data is always the clean encoding.

## Test plan
- Reset, then push 0xB3 → one cycle later out_data=0x553 (cw 7'b1010101, ip 3), occupancy=1.
- Push 0x05 then 0xFA back-to-back with out_ready=1 → outputs 0x005 then 0x7FA in order on consecutive cycles.
- out_ready=0, push 5 words with DEPTH=4 → in_ready drops after the 4th; the 5th is held until the first pop; order is preserved.
- Full FIFO with in_valid=1 and out_ready=1 → pop only that cycle, count goes 4→3; the push lands the next cycle.
- Assert rst_n=0 with 3 entries stored → immediately out_valid=0, occupancy=0; nothing is emitted after release.
- (HAMMING_ERR_INJECT_EN) arm pos=2, push 0xB3 → out_data=0x513; feeding the sink-side corrector restores 0xB3; the next 0xB3 gives 0x553.
